// File: rtl/servo_pkg.sv
// servo_pkg: cycle-count helpers and angle-to-width arithmetic shared by the servo PWM blocks
package servo_pkg;
  typedef logic [31:0] cyc_t;
  function automatic cyc_t us_to_cyc(input int unsigned clk_freq, input int unsigned us);
    return cyc_t'((clk_freq / 1_000_000) * us);
  endfunction
  function automatic int unsigned centre_angle(input int unsigned angle_w);
    return 32'd1 << (angle_w - 1);
  endfunction
  function automatic cyc_t angle_to_width(input longint unsigned angle, input int unsigned angle_w,
                                          input cyc_t min_cyc, input cyc_t span_cyc);
    return min_cyc + cyc_t'((angle * span_cyc) / ((64'd1 << angle_w) - 64'd1));
  endfunction
endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo output with a double-buffered pulse width and a per-frame step clamp
module servo_pwm_channel #(
  parameter int W = 16,
  parameter int RST_WIDTH = 0,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_width,
  input  logic         latch,
  input  logic         en,
  input  logic [W-1:0] frame_cnt,
  output logic         pwm
);
  logic [W-1:0] width_sh, width_act, diff, next_act;
  logic up;
  always_comb begin
    up = width_sh > width_act;
    diff = up ? width_sh - width_act : width_act - width_sh;
    next_act = diff <= W'(STEP) ? width_sh : up ? width_act + W'(STEP) : width_act - W'(STEP);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      width_sh <= W'(RST_WIDTH);
      width_act <= W'(RST_WIDTH);
      pwm <= 1'b0;
    end else begin
      if (wr) width_sh <= wr_width;
      if (latch) width_act <= next_act;
      pwm <= en && frame_cnt < width_act;
    end
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel servo PWM, shared frame counter, widths take effect at frame boundaries.
// Define SERVO_SLEW_LIMIT_EN to limit each width change to SLEW_STEP cycles per frame.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int N_CH = 4,
  parameter int ANGLE_W = 8,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US = 1000,
  parameter int MAX_US = 2000,
  parameter int SLEW_STEP = CLK_FREQ / 10_000,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [ANGLE_W-1:0] wr_angle,
  input  logic [N_CH-1:0]    ch_en,
  output logic [N_CH-1:0]    servo_pwm,
  output logic               cycle_done,
  output logic               wr_err
);
  localparam int PERIOD_CYC = int'(us_to_cyc(CLK_FREQ, PERIOD_US));
  localparam int MIN_CYC = int'(us_to_cyc(CLK_FREQ, MIN_US));
  localparam int SPAN_CYC = int'(us_to_cyc(CLK_FREQ, MAX_US - MIN_US));
  localparam int W = $clog2(PERIOD_CYC);
  localparam int PROD_W = ANGLE_W + $clog2(SPAN_CYC + 1);
  localparam int ANGLE_MAX = (1 << ANGLE_W) - 1;
  localparam int CENTRE_W = int'(angle_to_width(longint'(centre_angle(ANGLE_W)), ANGLE_W, MIN_CYC, SPAN_CYC));
`ifdef SERVO_SLEW_LIMIT_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif
  // Without slew limiting, a step wider than any possible width change makes the clamp a plain copy.
  localparam int STEP = SLEW_ON && SLEW_STEP < PERIOD_CYC ? SLEW_STEP : PERIOD_CYC - 1;
  logic [W-1:0] frame_cnt, new_width;
  logic [PROD_W-1:0] prod;
  logic last, bad_ch;
  always_comb begin
    last = frame_cnt == W'(PERIOD_CYC - 1);
    bad_ch = {1'b0, wr_ch} >= (CH_W + 1)'(N_CH);
    prod = PROD_W'(wr_angle) * PROD_W'(SPAN_CYC);
    new_width = W'(MIN_CYC) + W'(prod / PROD_W'(ANGLE_MAX));
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      frame_cnt <= '0;
      cycle_done <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      frame_cnt <= last ? '0 : frame_cnt + 1'b1;
      cycle_done <= frame_cnt == '0;
      wr_err <= wr_en && bad_ch;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_pwm_channel #(.W(W), .RST_WIDTH(CENTRE_W), .STEP(STEP)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .wr(wr_en && !bad_ch && wr_ch == CH_W'(i)),
      .wr_width(new_width),
      .latch(last),
      .en(ch_en[i]),
      .frame_cnt(frame_cnt),
      .pwm(servo_pwm[i])
    );
  end
endmodule
